fetch_queue: RTL

- Instruction fetch front end that sits directly upstream of the IF/DE pipeline register of the 5-stage-style MIPS pipeline.
- Owns the fetch PC and issues word-addressed requests to instruction memory under a single-cycle request/ack handshake.
- Buffers returned instructions, each paired with its PC+4, in a small FIFO; decode pops entries when not stalled.
- Handles branch redirect (flush) by discarding all buffered and in-flight work.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 71 +++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   INST_W / ADDR_W     : instruction width and word-address width
//   NOP_INST            : value presented to decode when the queue is empty
//   RESET_PC_DEFAULT    : default first fetch word address after reset
//   fetch_entry_t       : one queued fetch result {inst, pc_plus4}
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 30;

  localparam logic [INST_W-1:0] NOP_INST         = 32'h0;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 30'h100000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc_plus4;
  } fetch_entry_t;

  // Next sequential word address; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and decode.
//   imem_req/imem_addr/imem_ack/imem_data : single-cycle fetch request/ack
//   deq_valid/deq_inst/deq_pc_plus4/deq_ready : head-of-queue pop to decode
//   redirect/redirect_target              : branch flush and new fetch address
//   count                                 : current queue occupancy
// master = fetch_queue side, slave = memory/decode/branch side.
interface fetch_queue_if import fetch_pkg::*; #(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_data;

  logic              deq_valid;
  logic [INST_W-1:0] deq_inst;
  logic [ADDR_W-1:0] deq_pc_plus4;
  logic              deq_ready;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;

  logic [CNT_W-1:0]  count;

  modport master (
    output imem_req, imem_addr, deq_valid, deq_inst, deq_pc_plus4, count,
    input  imem_ack, imem_data, deq_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, deq_valid, deq_inst, deq_pc_plus4, count,
    output imem_ack, imem_data, deq_ready, redirect, redirect_target
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk        : clock
//   flush      : synchronous clear of pointers and occupancy (wins over push/pop)
//   push       : write push_entry at the tail
//   push_entry : entry to write
//   pop        : advance the head
//   head       : entry at the head (combinational read, meaningful when count!=0)
//   count      : occupancy 0..DEPTH
module fetch_fifo import fetch_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow; flush discards any concurrent request.
  assign do_push = push & ~flush & (occ != CNT_W'(DEPTH));
  assign do_pop  = pop  & ~flush & (occ != CNT_W'(0));

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign count = occ;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end feeding the IF/DE pipeline register.
// Owns the fetch PC, issues word-addressed requests to instruction memory,
// buffers {inst, pc_plus4} pairs in a small FIFO and flushes on redirect.
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : fetch_queue_if.master (imem handshake, decode pop, redirect, count)
module fetch_queue import fetch_pkg::*; #(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  occ;
  fetch_entry_t      head;
  fetch_entry_t      new_entry;
  logic              not_full;
  logic              head_valid;
  logic              enq;
  logic              deq;
  logic              flush;

  // Request whenever there is room, except while in reset or redirecting.
  assign not_full     = occ < CNT_W'(DEPTH);
  assign bus.imem_req = reset & ~bus.redirect & not_full;
  assign bus.imem_addr = fetch_pc;

  // Redirect blocks both enqueue (via imem_req) and dequeue.
  assign enq   = bus.imem_req & bus.imem_ack;
  assign head_valid = reset & (occ != CNT_W'(0));
  assign deq   = head_valid & bus.deq_ready & ~bus.redirect;
  assign flush = ~reset | bus.redirect;

  assign new_entry.inst     = bus.imem_data;
  assign new_entry.pc_plus4 = pc_next(fetch_pc);

  // Fetch PC: reset beats redirect, redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_target;
    end else if (enq) begin
      fetch_pc <= pc_next(fetch_pc);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .flush      (flush),
    .push       (enq),
    .push_entry (new_entry),
    .pop        (deq),
    .head       (head),
    .count      (occ)
  );

  // Empty queue presents a NOP bubble to decode.
  assign bus.deq_valid    = head_valid;
  assign bus.deq_inst     = head_valid ? head.inst     : NOP_INST;
  assign bus.deq_pc_plus4 = head_valid ? head.pc_plus4 : '0;
  assign bus.count        = occ;

endmodule
